mbist_march_ctrl: RTL and testbench

March C- BIST initiator that drives the single-port memory interface (write_read, address, wdata) and checks rdata.
- Targets the fault_mem style memory: registered write data, 2-cycle read latency, no memory reset.
- Sits between test-mode control (start/busy/done) and the memory under test.
- Reports pass/fail, the first failing address, bit syndrome, element index and fail count.

---
 rtl/mbist_march_if.sv | 32 +++
 rtl/mbist_march_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mbist_march_if.sv
// Bus between the March C- BIST controller, test-mode control and the
// single-port memory under test. The controller takes the master modport;
// the test environment / memory side takes the slave modport.
interface mbist_march_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [15:0]           fail_count;
    logic [ADDR_WIDTH-1:0] fail_addr;
    logic [DATA_WIDTH-1:0] fail_data;
    logic [2:0]            fail_element;
    logic                  write_read;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        input  start, rdata,
        output busy, done, pass, fail_count, fail_addr, fail_data, fail_element,
        output write_read, address, wdata
    );

    modport slave (
        output start, rdata,
        input  busy, done, pass, fail_count, fail_addr, fail_data, fail_element,
        input  write_read, address, wdata
    );
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller for a single-port memory with registered write
// data and 2-cycle read latency. Runs E0..E5, compares read data through a
// 2-stage expected-value pipeline and records the first failure.
// Optional build macro: MBIST_STOP_ON_FAIL_EN -- abort to DONE on the first
// mismatch instead of finishing the march.
module mbist_march_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 15
) (
    input  logic          clk,
    input  logic          rst,
    mbist_march_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_OP    = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY);

    // Value written by each element (E1/E3 write ones, the rest zeros).
    function automatic logic [DATA_WIDTH-1:0] elem_wval(input logic [2:0] e);
        return (e == 3'd1 || e == 3'd3) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
    endfunction

    // Value expected by each element's read (E2/E4 read ones).
    function automatic logic [DATA_WIDTH-1:0] elem_rval(input logic [2:0] e);
        return (e == 3'd2 || e == 3'd4) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
    endfunction

    function automatic logic elem_desc(input logic [2:0] e);
        return (e == 3'd3 || e == 3'd4);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] first_addr(input logic [2:0] e);
        return elem_desc(e) ? LAST_ADDR : '0;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic [2:0]            state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  phase_q, phase_d;
    logic                  drain_q, drain_d;

    logic [15:0]           fail_count_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [DATA_WIDTH-1:0] fail_data_q;
    logic [2:0]            fail_elem_q;

    logic                  vld_p0, vld_p1;
    logic [DATA_WIDTH-1:0] exp_p0, exp_p1;
    logic [ADDR_WIDTH-1:0] addr_p0, addr_p1;
    logic [2:0]            elem_p0, elem_p1;

    logic busy, arm, issue_rd, issue_wr, last_op, addr_end, mismatch, stop_hit;

    assign busy     = (state_q == S_SETUP) || (state_q == S_OP) || (state_q == S_DRAIN);
    assign arm      = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign issue_rd = (state_q == S_OP) && (elem_q != 3'd0) && ((elem_q == 3'd5) || !phase_q);
    assign issue_wr = (state_q == S_OP) && ((elem_q == 3'd0) || ((elem_q != 3'd5) && phase_q));
    assign last_op  = (elem_q == 3'd0) || (elem_q == 3'd5) || phase_q;
    assign addr_end = elem_desc(elem_q) ? (addr_q == '0) : (addr_q == LAST_ADDR);
    assign mismatch = busy && vld_p1 && (bus.rdata != exp_p1);

`ifdef MBIST_STOP_ON_FAIL_EN
    assign stop_hit = mismatch;
`else
    assign stop_hit = 1'b0;
`endif

    // Sequencer next state: element, address and read/write phase walk.
    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_SETUP;
                    elem_d  = 3'd0;
                    addr_d  = first_addr(3'd0);
                end
            end
            S_SETUP: begin
                state_d = S_OP;
                phase_d = 1'b0;
            end
            S_OP: begin
                if (!last_op) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (addr_end) begin
                        if (elem_q == 3'd5) begin
                            state_d = S_DRAIN;
                            drain_d = 1'b0;
                        end else begin
                            state_d = S_SETUP;
                            elem_d  = elem_q + 3'd1;
                            addr_d  = first_addr(elem_q + 3'd1);
                        end
                    end else if (elem_desc(elem_q)) begin
                        addr_d = addr_q - ADDR_WIDTH'(1);
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q) state_d = S_DONE;
                else         drain_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (stop_hit) state_d = S_DONE;
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            elem_q  <= 3'd0;
            addr_q  <= '0;
            phase_q <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            drain_q <= drain_d;
        end
    end

    // Stage boundary p0/p1: read-issue valids, flushed when the test aborts.
    always_ff @(posedge clk) begin
        if (rst || stop_hit) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= issue_rd;
            vld_p1 <= vld_p0;
        end
    end

    // Stage boundary p0/p1: expected data, address and element of each read.
    always_ff @(posedge clk) begin
        exp_p0  <= elem_rval(elem_q);
        addr_p0 <= addr_q;
        elem_p0 <= elem_q;
        exp_p1  <= exp_p0;
        addr_p1 <= addr_p0;
        elem_p1 <= elem_p0;
    end

    // Failure bookkeeping: saturating count plus first-failure snapshot.
    always_ff @(posedge clk) begin
        if (rst || arm) begin
            fail_count_q <= '0;
            fail_addr_q  <= '0;
            fail_data_q  <= '0;
            fail_elem_q  <= '0;
        end else if (mismatch) begin
            fail_count_q <= sat_inc(fail_count_q);
            if (fail_count_q == 16'd0) begin
                fail_addr_q <= addr_p1;
                fail_data_q <= bus.rdata ^ exp_p1;
                fail_elem_q <= elem_p1;
            end
        end
    end

    assign bus.busy         = busy;
    assign bus.done         = (state_q == S_DONE);
    assign bus.pass         = (state_q == S_DONE) && (fail_count_q == 16'd0);
    assign bus.fail_count   = fail_count_q;
    assign bus.fail_addr    = fail_addr_q;
    assign bus.fail_data    = fail_data_q;
    assign bus.fail_element = fail_elem_q;
    assign bus.write_read   = issue_wr && !stop_hit;
    assign bus.address      = addr_q;
    assign bus.wdata        = elem_wval(elem_q);
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: behavioural fault_mem-style memory with
// injectable stuck-at / coupling faults, and a March C- reference computed
// by walking the algorithm over an array.
module tb_mbist_march_ctrl;
    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int CAP = 15;
    localparam int N   = CAP + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mbist_march_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Fault configuration: 0 none, 1 stuck-at, 2 coupling (rising aggressor bit flips victim bit)
    int fault_kind = 0;
    int sa_addr = 0, sa_bit = 0, sa_val = 0;
    int cp_agg = 0, cp_vic = 1, cp_bit = 0;

    logic [DW-1:0] mem [N];
    logic [DW-1:0] wd_prev;
    logic [DW-1:0] rd_s1;
    logic [AW-1:0] wl_addr [$];
    logic [DW-1:0] wl_data [$];

    function automatic logic [DW-1:0] fread(input logic [DW-1:0] v, input int a);
        logic [DW-1:0] r;
        r = v;
        if (fault_kind == 1 && a == sa_addr) r[sa_bit] = sa_val[0];
        return r;
    endfunction

    // Memory: registered write data, 2-cycle read latency, no reset.
    always @(posedge clk) begin
        wd_prev   <= bus.wdata;
        rd_s1     <= fread(mem[bus.address], int'(bus.address));
        bus.rdata <= rd_s1;
        if (bus.write_read) begin
            mem[bus.address] <= wd_prev;
            if (fault_kind == 2 && int'(bus.address) == cp_agg &&
                !mem[cp_agg][cp_bit] && wd_prev[cp_bit])
                mem[cp_vic][cp_bit] <= ~mem[cp_vic][cp_bit];
            wl_addr.push_back(bus.address);
            wl_data.push_back(wd_prev);
        end
    end

    // Reference results
    logic [DW-1:0] ref_m [N];
    int r_cnt, r_addr, r_data, r_elem, r_fcyc, r_busy, r_wr;
    int wr_cyc [$];

    function automatic void ref_march();
        int cyc, a;
        logic [DW-1:0] v, ev, wv;
        r_cnt = 0; r_addr = 0; r_data = 0; r_elem = 0; r_fcyc = -1; cyc = 0;
        wr_cyc.delete();
        for (int i = 0; i < N; i++) ref_m[i] = '0;
        for (int e = 0; e < 6; e++) begin
            cyc++;
            for (int k = 0; k < N; k++) begin
                a = (e == 3 || e == 4) ? CAP - k : k;
                if (e != 0) begin
                    ev = (e == 2 || e == 4) ? 8'hFF : 8'h00;
                    v  = fread(ref_m[a], a);
                    if (v !== ev) begin
                        if (r_cnt == 0) begin
                            r_addr = a; r_data = int'(v ^ ev); r_elem = e; r_fcyc = cyc;
                        end
                        r_cnt++;
                    end
                    cyc++;
                end
                if (e != 5) begin
                    wv = (e == 1 || e == 3) ? 8'hFF : 8'h00;
                    if (fault_kind == 2 && a == cp_agg && !ref_m[a][cp_bit] && wv[cp_bit])
                        ref_m[cp_vic][cp_bit] = ~ref_m[cp_vic][cp_bit];
                    ref_m[a] = wv;
                    wr_cyc.push_back(cyc);
                    cyc++;
                end
            end
        end
        r_busy = cyc + 2;
        r_wr   = wr_cyc.size();
`ifdef MBIST_STOP_ON_FAIL_EN
        if (r_cnt > 0) begin
            r_cnt  = 1;
            r_busy = r_fcyc + 3;
            r_wr   = 0;
            foreach (wr_cyc[i]) if (wr_cyc[i] < r_fcyc + 2) r_wr++;
        end
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Launch a march from IDLE/DONE, optionally pulse start mid-run, then
    // compare the whole outcome with the reference.
    task automatic run_march(input string tag, input int pulse_at);
        int blen, wr0;
        ref_march();
        wr0 = wl_addr.size();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        check({tag, "_start_busy"}, bus.busy, 1);
        check({tag, "_start_done"}, bus.done, 0);
        blen = 0;
        while (bus.busy === 1'b1 && blen < 3000) begin
            bus.start = (blen == pulse_at);
            blen++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, "_busy_len"},   blen, r_busy);
        check({tag, "_done"},       bus.done, 1);
        check({tag, "_pass"},       bus.pass, (r_cnt == 0));
        check({tag, "_fail_count"}, bus.fail_count, r_cnt);
        check({tag, "_fail_addr"},  bus.fail_addr, r_addr);
        check({tag, "_fail_data"},  bus.fail_data, r_data);
        check({tag, "_fail_elem"},  bus.fail_element, r_elem);
        check({tag, "_writes"},     wl_addr.size() - wr0, r_wr);
    endtask

    initial begin
        int base;
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy",       bus.busy, 0);
        check("rst_done",       bus.done, 0);
        check("rst_pass",       bus.pass, 0);
        check("rst_fail_count", bus.fail_count, 0);
        check("rst_write_read", bus.write_read, 0);
        check("rst_address",    bus.address, 0);
        check("rst_wdata",      bus.wdata, 0);
        check("rst_fail_addr",  bus.fail_addr, 0);

        // start coincident with reset is ignored
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("rst_start_busy", bus.busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // fault-free run, plus write order/data of E0 and E1's first write
        fault_kind = 0;
        base = wl_addr.size();
        run_march("clean", -1);
        for (int i = 0; i < N; i++) begin
            check("e0_wr_addr", wl_addr[base + i], i);
            check("e0_wr_data", wl_data[base + i], 0);
        end
        check("e1_wr_addr", wl_addr[base + N], 0);
        check("e1_wr_data", wl_data[base + N], 8'hFF);
        for (int i = 0; i < N; i++) check("final_mem", mem[i], 0);

        // stuck-at-1, bit 0, address 3
        fault_kind = 1; sa_addr = 3; sa_bit = 0; sa_val = 1;
        run_march("sa1_a3b0", -1);

        // coupling: address 4 bit 5 rising flips address 5 bit 5
        fault_kind = 2; cp_agg = 4; cp_vic = 5; cp_bit = 5;
        run_march("cf_4_5", -1);

        // randomized stuck-at faults
        for (int t = 0; t < 4; t++) begin
            fault_kind = 1;
            sa_addr = $urandom_range(0, CAP);
            sa_bit  = $urandom_range(0, DW - 1);
            sa_val  = $urandom_range(0, 1);
            run_march("rand_sa", -1);
        end

        // randomized coupling faults
        for (int t = 0; t < 3; t++) begin
            fault_kind = 2;
            cp_agg = $urandom_range(0, CAP);
            cp_vic = (cp_agg + $urandom_range(1, CAP)) % N;
            cp_bit = $urandom_range(0, DW - 1);
            run_march("rand_cf", -1);
        end

        // start pulse while busy must not disturb the run
        fault_kind = 0;
        run_march("busy_pulse", 40);

        // done holds in DONE until the next start
        repeat (3) @(negedge clk);
        check("done_hold", bus.done, 1);

        // reset in the middle of E2 with a failure already counted
        fault_kind = 1; sa_addr = 3; sa_bit = 0; sa_val = 1;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (60) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy",       bus.busy, 0);
        check("midrst_write_read", bus.write_read, 0);
        check("midrst_fail_count", bus.fail_count, 0);
        check("midrst_done",       bus.done, 0);
        rst = 1'b0;
        fault_kind = 0;
        run_march("after_rst", -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
